// File: rtl/lifo_pkg.sv
// Shared definitions for the parameterised LIFO: count-width helper, {push,pop} op-codes,
// and reset values for the data outputs.
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } lifo_op_e;

  localparam logic DATA_RST_BIT = 1'b0;
  localparam logic FLAG_RST     = 1'b0;

  // Bits needed to represent 0..depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module lifo_mem
  import lifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_lifo.sv
// Parameterised synchronous LIFO with registered pop data, occupancy count and error flags.
// Optional macro LIFO_ERR_STICKY_EN makes overflow/underflow sticky until reset.
module param_lifo
  import lifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  lifo_op_e         op_c;
  logic             we_c;
  logic             mem_we_c;
  logic [AW-1:0]    waddr_c;
  logic [AW-1:0]    raddr_c;
  logic [WIDTH-1:0] rdata_c;

  // Top-of-stack address; parked at 0 when empty so the read stays in range
  assign raddr_c  = empty_q ? '0 : AW'(count_q - CW'(1));
  assign mem_we_c = we_c & ~rst;

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (waddr_c),
    .wdata (din),
    .raddr (raddr_c),
    .rdata (rdata_c)
  );

  always_comb begin
    op_c         = lifo_op_e'({push, pop});
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    we_c         = 1'b0;
    waddr_c      = AW'(count_q);
`ifdef LIFO_ERR_STICKY_EN
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
`else
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
`endif

    case (op_c)
      OP_POP: begin
        if (!empty_q) begin
          dout_d       = rdata_c;
          dout_valid_d = 1'b1;
          count_d      = count_q - CW'(1);
        end else begin
          underflow_d  = 1'b1;
        end
      end
      OP_PUSH: begin
        if (!full_q) begin
          we_c    = 1'b1;
          count_d = count_q + CW'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
      OP_SWAP: begin
        // Non-empty: replace the top in place; empty: din passes straight to dout
        dout_valid_d = 1'b1;
        if (!empty_q) begin
          dout_d  = rdata_c;
          we_c    = 1'b1;
          waddr_c = raddr_c;
        end else begin
          dout_d  = din;
        end
      end
      default: ;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      dout_q       <= {WIDTH{DATA_RST_BIT}};
      dout_valid_q <= FLAG_RST;
      overflow_q   <= FLAG_RST;
      underflow_q  <= FLAG_RST;
    end else begin
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign top        = empty_q ? {WIDTH{DATA_RST_BIT}} : rdata_c;

endmodule

// File: tb/tb_param_lifo.sv
// Bench for param_lifo (WIDTH=8, DEPTH=4): queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_param_lifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic             clk = 1'b0;
  logic             rst, push, pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout, top;
  logic             dout_valid, empty, full, overflow, underflow;
  logic [CW-1:0]    count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid, m_ovf, m_udf;

  always #5 clk = ~clk;

  param_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(dout), .dout_valid(dout_valid), .top(top), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic p, input logic o, input logic [WIDTH-1:0] d);
    if (r) begin
      m_q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_valid = 1'b0;
`ifndef LIFO_ERR_STICKY_EN
      m_ovf = 1'b0;
      m_udf = 1'b0;
`endif
      if (p && o) begin
        m_valid = 1'b1;
        if (m_q.size() == 0) m_dout = d;
        else begin
          m_dout = m_q[m_q.size()-1];
          m_q[m_q.size()-1] = d;
        end
      end else if (p) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1'b1;
      end else if (o) begin
        if (m_q.size() > 0) begin
          m_dout = m_q.pop_back();
          m_valid = 1'b1;
        end else m_udf = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    logic [WIDTH-1:0] exp_top;
    exp_top = (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
    check("count",      32'(count),      32'(m_q.size()));
    check("empty",      32'(empty),      32'(m_q.size() == 0));
    check("full",       32'(full),       32'(m_q.size() == DEPTH));
    check("dout",       32'(dout),       32'(m_dout));
    check("dout_valid", 32'(dout_valid), 32'(m_valid));
    check("top",        32'(top),        32'(exp_top));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("underflow",  32'(underflow),  32'(m_udf));
  endtask

  // Drive one request, advance an edge, update model, sample #1 later and compare
  task automatic cycle(input logic r, input logic p, input logic o, input logic [WIDTH-1:0] d);
    rst = r; push = p; pop = o; din = d;
    @(posedge clk);
    model_step(r, p, o, d);
    #1;
    compare_model();
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    cycle(1, 0, 0, 8'h00);
    cycle(1, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout",  32'(dout),  32'd0);
    check("rst_top",   32'(top),   32'd0);

    // Fill to full, then one rejected push
    cycle(0, 1, 0, 8'h11);
    check("top_after_push", 32'(top), 32'h11);
    cycle(0, 1, 0, 8'h22);
    cycle(0, 1, 0, 8'h33);
    cycle(0, 1, 0, 8'h44);
    cycle(0, 1, 0, 8'h55);
    check("ovf_pulse",  32'(overflow), 32'd1);
    check("full_lit",   32'(full),     32'd1);
    check("count_full", 32'(count),    32'd4);
    cycle(0, 0, 1, 8'h00); check("pop1", 32'(dout), 32'h44);
    cycle(0, 0, 1, 8'h00); check("pop2", 32'(dout), 32'h33);
    cycle(0, 0, 1, 8'h00); check("pop3", 32'(dout), 32'h22);
    cycle(0, 0, 1, 8'h00); check("pop4", 32'(dout), 32'h11);
    check("pop_valid", 32'(dout_valid), 32'd1);
    check("drained_empty", 32'(empty), 32'd1);

    // Underflow on empty
    cycle(0, 0, 1, 8'h00);
    check("udf_pulse", 32'(underflow), 32'd1);
    check("udf_dout",  32'(dout),      32'h11);
    cycle(0, 0, 0, 8'h00);

    // Swap mid-stack and at full
    cycle(1, 0, 0, 8'h00);
    cycle(0, 1, 0, 8'hA1);
    cycle(0, 1, 0, 8'hB2);
    cycle(0, 1, 1, 8'hC3);
    check("swap_dout",  32'(dout),  32'hB2);
    check("swap_count", 32'(count), 32'd2);
    check("swap_top",   32'(top),   32'hC3);
    cycle(0, 1, 0, 8'hD4);
    cycle(0, 1, 0, 8'hE5);
    cycle(0, 1, 1, 8'hF6);
    check("swapfull_ovf",   32'(overflow), 32'd0);
    check("swapfull_count", 32'(count),    32'd4);
    check("swapfull_dout",  32'(dout),     32'hE5);

    // Pass-through on empty
    cycle(1, 0, 0, 8'h00);
    cycle(0, 1, 1, 8'h5A);
    check("pass_dout",  32'(dout),       32'h5A);
    check("pass_valid", 32'(dout_valid), 32'd1);
    check("pass_count", 32'(count),      32'd0);
    check("pass_udf",   32'(underflow),  32'd0);

    // Reset wins over a concurrent push
    cycle(0, 1, 0, 8'h01);
    cycle(0, 1, 0, 8'h02);
    cycle(0, 1, 0, 8'h03);
    cycle(1, 1, 0, 8'h04);
    check("rstpush_count", 32'(count),    32'd0);
    check("rstpush_empty", 32'(empty),    32'd1);
    check("rstpush_ovf",   32'(overflow), 32'd0);
    cycle(0, 1, 0, 8'h77);
    cycle(0, 0, 1, 8'h00);
    check("after_rst_pop", 32'(dout), 32'h77);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_lifo.md
Name: param_lifo

Overview:
Parameterised synchronous LIFO (stack) buffer with independent push/pop strobes, a registered pop data path, an occupancy count and error pulses. It is the next-generation stack primitive for datapaths that need last-in-first-out buffering, such as return-address stacks and nested-context save/restore. Width and depth are generic. A simultaneous push and pop performs an atomic top-of-stack swap.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, any integer, not restricted to powers of two)
CW, $clog2(DEPTH+1), count width; derived, not to be overridden

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
push  input  1  write request
din  input  WIDTH  write data, sampled when push=1
pop  input  1  read request
dout  output  WIDTH  registered pop data
dout_valid  output  1  one-cycle pulse, dout updated this cycle
top  output  WIDTH  combinational peek of top entry, 0 when empty
count  output  CW  number of stored entries, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  one-cycle pulse, push rejected
underflow  output  1  one-cycle pulse, pop rejected

Behaviour:
- Reset (rst=1 at an edge) wins over all requests:
  - count=0, empty=1, full=0.
  - dout=0, dout_valid=0, overflow=0, underflow=0.
  - Memory contents are not cleared. top reads 0 because the stack is empty.
- empty and full are registered and updated on the same edge as count. They are never stale relative to count.
- push only, not full: mem[count]<=din; count+1. The new entry appears on top the next cycle.
- push only, full: entry dropped; count, memory and dout unchanged; overflow=1 for one cycle.
- pop only, not empty: dout<=mem[count-1]; dout_valid=1 next cycle; count-1. Latency is 1 clock from the pop edge to valid data.
- pop only, empty: dout holds its previous value; dout_valid=0; underflow=1 for one cycle.
- push+pop, not empty (including full): swap.
  - dout<=mem[count-1]; dout_valid=1.
  - mem[count-1]<=din; count unchanged.
  - No overflow.
- push+pop, empty: pass-through.
  - dout<=din; dout_valid=1.
  - count stays 0; no underflow.
- Idle (neither request): dout holds; dout_valid=0.
- Reset mid-operation: any request in the reset cycle is discarded, and no error pulses are raised.
- count arithmetic is CW-bit. The full/empty guards guarantee no wrap-around, so count never exceeds DEPTH and never underflows.

Optional Feature:
Macro: LIFO_ERR_STICKY_EN
- Defined: overflow and underflow become sticky. Once set, they stay at 1 until rst. Data behaviour is identical.
- Undefined: overflow and underflow are single-cycle pulses as described in Behaviour.

Decomposition:
- Shared package/header lifo_pkg holds:
  - the count-width function (clog2 of DEPTH+1);
  - the op-code encoding of {push,pop}: IDLE=2'b00, POP=2'b01, PUSH=2'b10, SWAP=2'b11;
  - reset values for the data outputs.
- One sub-module, lifo_mem:
  - DEPTH x WIDTH register array;
  - one synchronous write port (addr, data, we);
  - one asynchronous read port, used for both top and the pop read.
- param_lifo keeps the count register, flag logic, op decode and the output registers.

Test Plan:
(All cases use WIDTH=8, DEPTH=4.)
- Reset then idle 2 cycles -> count=0, empty=1, full=0, dout=0, dout_valid=0, top=0.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles, then push 0x55 -> full=1, count=4, overflow pulses in the 0x55 cycle. Then pop x4 -> dout=0x44,0x33,0x22,0x11, each with dout_valid, 1-cycle latency; ends empty=1.
- Pop on an empty stack -> underflow=1 for one cycle (sticky with LIFO_ERR_STICKY_EN), dout unchanged, count=0.
- Stack holds 0xA1,0xB2 (count=2); push+pop with din=0xC3 -> dout=0xB2, dout_valid=1, count=2, top=0xC3. Repeat the swap at full (count=4) -> no overflow, count=4.
- Empty stack; push+pop with din=0x5A -> dout=0x5A, dout_valid=1, count=0, no underflow.
- Push 3 entries, assert rst together with push=1 -> next cycle count=0, empty=1, no overflow. Then push 0x77 and pop -> dout=0x77.
